// File: rtl/pipelined_cia_adder_if.sv
// Operand/result handshake bundle for pipelined_cia_adder.
// The overflow signal exists only when CIA_OVERFLOW_EN is defined.
interface pipelined_cia_adder_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
`ifdef CIA_OVERFLOW_EN
  logic             overflow;

  modport master (output in_valid, a, b, carry_in, sub, out_ready,
                  input  in_ready, out_valid, sum, carry_out, overflow);
  modport slave  (input  in_valid, a, b, carry_in, sub, out_ready,
                  output in_ready, out_valid, sum, carry_out, overflow);
`else
  modport master (output in_valid, a, b, carry_in, sub, out_ready,
                  input  in_ready, out_valid, sum, carry_out);
  modport slave  (input  in_valid, a, b, carry_in, sub, out_ready,
                  output in_ready, out_valid, sum, carry_out);
`endif
endinterface

// File: rtl/pipelined_cia_adder.sv
// Two-stage carry-increment adder/subtractor with valid/ready flow control.
// Define CIA_OVERFLOW_EN to add the registered signed-overflow output.
module pipelined_cia_adder #(
  parameter int WIDTH = 32,
  parameter int BLK   = 8
) (
  input logic                 clk,
  input logic                 rst,
  pipelined_cia_adder_if.slave bus
);
  localparam int NBLK   = WIDTH / BLK;
  localparam int STAGES = 2;

  logic [STAGES:1]          vld_pipe;
  logic                     adv2;
  logic [NBLK-1:0][BLK-1:0] a_blk, b_blk, s_blk;
  logic [NBLK-1:0]          g_blk, p_blk;
  logic                     c0;

  logic [NBLK-1:0][BLK-1:0] s1_sum;
  logic [NBLK-1:0]          s1_g, s1_p;
  logic                     s1_c0;

  logic [NBLK-1:0][BLK-1:0] sum_nxt, sum_q;
  logic                     co_nxt, co_q;

  assign a_blk = bus.a;
  assign b_blk = bus.sub ? ~bus.b : bus.b;
  assign c0    = bus.carry_in ^ bus.sub;

  // Per-block lookahead with carry-in tied to 0; the real carry is applied in stage 2.
  for (genvar k = 0; k < NBLK; k++) begin : g_lane
    always_comb begin : blk_add
      logic cy;
      cy       = 1'b0;
      s_blk[k] = '0;
      for (int i = 0; i < BLK; i++) begin
        s_blk[k][i] = a_blk[k][i] ^ b_blk[k][i] ^ cy;
        cy          = (a_blk[k][i] & b_blk[k][i]) | ((a_blk[k][i] ^ b_blk[k][i]) & cy);
      end
      g_blk[k] = cy;
      p_blk[k] = &(a_blk[k] ^ b_blk[k]);
    end
  end

  // Stage 2: ripple the block carries and increment each block sum by its carry-in.
  always_comb begin : blk_inc
    logic cy;
    cy      = s1_c0;
    sum_nxt = '0;
    for (int k = 0; k < NBLK; k++) begin
      sum_nxt[k] = s1_sum[k] + {{(BLK-1){1'b0}}, cy};
      cy         = s1_g[k] | (s1_p[k] & cy);
    end
    co_nxt = cy;
  end

  assign adv2         = !vld_pipe[2] || bus.out_ready;
  assign bus.in_ready = !rst && (!vld_pipe[1] || adv2);

`ifdef CIA_OVERFLOW_EN
  logic s1_a_msb, s1_b_msb, ov_nxt, ov_q;
  assign ov_nxt       = (s1_a_msb == s1_b_msb) && (sum_nxt[NBLK-1][BLK-1] != s1_a_msb);
  assign bus.overflow = ov_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_a_msb <= 1'b0;
      s1_b_msb <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      if (adv2 && vld_pipe[1]) ov_q <= ov_nxt;
      if (bus.in_ready && bus.in_valid) begin
        s1_a_msb <= a_blk[NBLK-1][BLK-1];
        s1_b_msb <= b_blk[NBLK-1][BLK-1];
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_sum   <= '0;
      s1_g     <= '0;
      s1_p     <= '0;
      s1_c0    <= 1'b0;
      sum_q    <= '0;
      co_q     <= 1'b0;
    end else begin
      if (adv2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          sum_q <= sum_nxt;
          co_q  <= co_nxt;
        end
      end
      // in_ready already folds in stage-2 movement, so stage 1 never overwrites a stuck beat.
      if (bus.in_ready) begin
        vld_pipe[1] <= bus.in_valid;
        if (bus.in_valid) begin
          s1_sum <= s_blk;
          s1_g   <= g_blk;
          s1_p   <= p_blk;
          s1_c0  <= c0;
        end
      end
    end
  end

  assign bus.out_valid = vld_pipe[2];
  assign bus.sum       = sum_q;
  assign bus.carry_out = co_q;
endmodule

// File: tb/tb_pipelined_cia_adder.sv
// Directed bench for pipelined_cia_adder: latency, carry/borrow vectors, stall and reset.
// Overflow checks are compiled in only when CIA_OVERFLOW_EN is defined.
module tb_pipelined_cia_adder;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [W:0] got_q[$];

  always #5 clk = ~clk;

  pipelined_cia_adder_if #(.WIDTH(W)) bus ();
  pipelined_cia_adder #(.WIDTH(W), .BLK(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Record {carry_out, sum} of every beat that the next rising edge delivers.
  always @(negedge clk)
    if (!rst && bus.out_valid && bus.out_ready) got_q.push_back({bus.carry_out, bus.sum});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic s);
    bus.a = a; bus.b = b; bus.carry_in = cin; bus.sub = s;
  endtask

  // Offer one beat, wait (bounded) for acceptance, then withdraw in_valid.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic s);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    drive(a, b, cin, s);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    chk("accept", 64'(ok), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run1(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic s, input logic [W-1:0] e_sum,
                      input logic e_co, input logic e_ov);
    send(a, b, cin, s);
    @(negedge clk);
    chk({tag, "_vld_edge1"}, 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_vld_edge2"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_sum"}, 64'(bus.sum), 64'(e_sum));
    chk({tag, "_cout"}, 64'(bus.carry_out), 64'(e_co));
`ifdef CIA_OVERFLOW_EN
    chk({tag, "_ovf"}, 64'(bus.overflow), 64'(e_ov));
`else
    if (e_ov === 1'bx) chk({tag, "_ovf_arg"}, 64'(e_ov), 64'd0);
`endif
  endtask

  initial begin
    logic [W:0] v;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_sum", 64'(bus.sum), 64'd0);
    chk("rst_cout", 64'(bus.carry_out), 64'd0);
`ifdef CIA_OVERFLOW_EN
    chk("rst_ovf", 64'(bus.overflow), 64'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Single beats with hand-computed results.
    run1("wrap",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run1("blk3",     32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
    run1("sub5m7",   32'd5,         32'd7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run1("posovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run1("sub_bin",  32'd10,        32'd3,         1'b1, 1'b1, 32'd6,         1'b1, 1'b0);
    run1("negovf",   32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b1);
    run1("cin_prop", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);

    // Back-to-back stream into a stalled output.
    repeat (3) @(posedge clk);
    #1;
    got_q.delete();
    bus.out_ready = 1'b0;
    drive(32'd1, 32'd1, 1'b0, 1'b0); bus.in_valid = 1'b1;
    @(negedge clk); chk("stall_rdy_b1", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    drive(32'd2, 32'd2, 1'b0, 1'b0);
    @(negedge clk); chk("stall_rdy_b2", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    drive(32'd3, 32'd3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_sum", 64'(bus.sum), 64'd2);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk); chk("rel_rdy_b3", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    drive(32'd4, 32'd4, 1'b0, 1'b0);
    @(negedge clk); chk("rel_rdy_b4", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (got_q.size() >= 4) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("stream_count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (got_q.size() == 0) break;
      v = got_q.pop_front();
      chk("stream_order", 64'(v), 64'(2 * (i + 1)));
    end

    // Reset with two beats in flight.
    got_q.delete();
    bus.out_ready = 1'b0;
    send(32'd9, 32'd9, 1'b0, 1'b0);
    send(32'd10, 32'd10, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_sum", 64'(bus.sum), 64'd0);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("flush_rdy_after", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("flush_no_emit", 64'(got_q.size()), 64'd0);
    chk("flush_idle_valid", 64'(bus.out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
